fractal_sync_cnt_rf: RTL and testbench



---
 rtl/fractal_sync_pkg.sv | 18 +
 rtl/fractal_sync_cnt_entry.sv | 95 +++++++++
 rtl/fractal_sync_cnt_rf.sv | 127 ++++++++++++
 tb/tb_fractal_sync_cnt_rf.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fractal_sync_pkg.sv
// Shared types and helpers for the fractal sync node.
// SD_WIDTH sizes the back-routing source/destination mask.
package fractal_sync_pkg;

   localparam int unsigned SD_WIDTH = 4;

   typedef logic [SD_WIDTH-1:0] sd_t;

   function automatic int unsigned popcount_ports(input logic [31:0] vec);
      int unsigned cnt;
      cnt = 0;
      for (int i = 0; i < 32; i++) begin
         if (vec[i]) cnt++;
      end
      return cnt;
   endfunction

endpackage

// File: rtl/fractal_sync_cnt_entry.sv
// One barrier entry: arrival counter, captured target and sticky SD mask.
// Target-mismatch detection is built only with FRACTAL_SYNC_CNT_RF_ERR_EN.
module fractal_sync_cnt_entry
   import fractal_sync_pkg::*;
#(
   parameter int unsigned N_PORTS   = 2,
   parameter int unsigned CNT_WIDTH = 4
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                flush_i,
   input  logic [N_PORTS-1:0]                  hit_i,
   input  logic [N_PORTS-1:0][CNT_WIDTH-1:0]   tgt_i,
   input  sd_t  [N_PORTS-1:0]                  sd_i,
   output logic                                busy_o,
   output logic                                release_o,
   output sd_t                                 relSd_o,
   output logic [N_PORTS-1:0]                  err_o
);

   localparam int unsigned SUM_W = CNT_WIDTH + $clog2(N_PORTS + 1);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] tgt_q, tgt_d;
   sd_t                  sd_q, sd_d;

   logic [SUM_W-1:0]     arrivals;
   logic [SUM_W-1:0]     sum;
   logic [SUM_W-1:0]     effTgt;
   logic [CNT_WIDTH-1:0] firstTgt;
   logic [CNT_WIDTH-1:0] rawTgt;
   sd_t                  arriveSd;
   logic                 anyHit;

   // Walk ports high-to-low so the lowest-index arrival's target wins.
   always_comb begin
      arriveSd = '0;
      firstTgt = '0;
      for (int p = int'(N_PORTS) - 1; p >= 0; p--) begin
         if (hit_i[p]) begin
            arriveSd = arriveSd | sd_i[p];
            firstTgt = tgt_i[p];
         end
      end
   end

   assign anyHit    = |hit_i;
   assign arrivals  = SUM_W'(popcount_ports(32'(hit_i)));
   assign rawTgt    = (cnt_q == '0) ? firstTgt : tgt_q;
   assign effTgt    = (rawTgt == '0) ? SUM_W'(1) : SUM_W'(rawTgt);
   assign sum       = SUM_W'(cnt_q) + arrivals;
   assign release_o = anyHit && (sum >= effTgt);
   assign relSd_o   = sd_q | arriveSd;
   assign busy_o    = (cnt_q != '0);

   always_comb begin
      cnt_d = cnt_q;
      tgt_d = tgt_q;
      sd_d  = sd_q;
      if (flush_i || release_o) begin
         cnt_d = '0;
         tgt_d = '0;
         sd_d  = '0;
      end else if (anyHit) begin
         cnt_d = sum[CNT_WIDTH-1:0];
         sd_d  = sd_q | arriveSd;
         if (cnt_q == '0) tgt_d = firstTgt;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         tgt_q <= '0;
         sd_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         tgt_q <= tgt_d;
         sd_q  <= sd_d;
      end
   end

`ifdef FRACTAL_SYNC_CNT_RF_ERR_EN
   // A fresh entry compares against the lowest port's target, so every differing port is flagged.
   always_comb begin
      err_o = '0;
      for (int p = 0; p < int'(N_PORTS); p++) begin
         err_o[p] = hit_i[p] && (tgt_i[p] != rawTgt);
      end
   end
`else
   assign err_o = '0;
`endif

endmodule

// File: rtl/fractal_sync_cnt_rf.sv
// Multi-port counting barrier register file with sticky SD back-routing masks.
// Define FRACTAL_SYNC_CNT_RF_ERR_EN to build the target-mismatch flag on err_o.
module fractal_sync_cnt_rf
   import fractal_sync_pkg::*;
#(
   parameter int unsigned N_REGS    = 4,
   parameter int unsigned IDX_WIDTH = 2,
   parameter int unsigned N_PORTS   = 2,
   parameter int unsigned CNT_WIDTH = 4
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                flush_i,
   input  logic [N_PORTS-1:0]                  arrive_i,
   input  logic [N_PORTS-1:0][IDX_WIDTH-1:0]   idx_i,
   input  logic [N_PORTS-1:0][CNT_WIDTH-1:0]   tgt_i,
   input  sd_t  [N_PORTS-1:0]                  sd_i,
   output logic [N_PORTS-1:0]                  present_o,
   output logic [N_PORTS-1:0]                  rel_o,
   output sd_t  [N_PORTS-1:0]                  rel_sd_o,
   output logic [N_PORTS-1:0]                  err_o
);

   localparam int unsigned SELW = (N_REGS > 1) ? $clog2(N_REGS) : 1;

   if ((2 ** IDX_WIDTH) < N_REGS) begin : gIdxCheck
      $fatal(1, "fractal_sync_cnt_rf: IDX_WIDTH too small for N_REGS");
   end

   logic [N_PORTS-1:0][SELW-1:0]    sel;
   logic [N_REGS-1:0][N_PORTS-1:0]  hit;
   logic [N_REGS-1:0][N_PORTS-1:0]  entryErr;
   logic [N_REGS-1:0]               entryBusy;
   logic [N_REGS-1:0]               entryRel;
   sd_t  [N_REGS-1:0]               entryRelSd;

   logic [N_PORTS-1:0]              rel_d, rel_q;
   sd_t  [N_PORTS-1:0]              relSd_d, relSd_q;
   logic                            unusedIdx;

   assign unusedIdx = ^idx_i;

   always_comb begin
      hit       = '0;
      present_o = '0;
      for (int p = 0; p < int'(N_PORTS); p++) begin
         sel[p] = idx_i[p][SELW-1:0];
         for (int e = 0; e < int'(N_REGS); e++) begin
            if (sel[p] == SELW'(e)) begin
               hit[e][p]    = arrive_i[p];
               present_o[p] = arrive_i[p] && entryBusy[e];
            end
         end
      end
   end

   for (genvar e = 0; e < N_REGS; e++) begin : gEntry
      fractal_sync_cnt_entry #(
         .N_PORTS   (N_PORTS),
         .CNT_WIDTH (CNT_WIDTH)
      ) uEntry (
         .clk_i     (clk_i),
         .rst_ni    (rst_ni),
         .flush_i   (flush_i),
         .hit_i     (hit[e]),
         .tgt_i     (tgt_i),
         .sd_i      (sd_i),
         .busy_o    (entryBusy[e]),
         .release_o (entryRel[e]),
         .relSd_o   (entryRelSd[e]),
         .err_o     (entryErr[e])
      );
   end

   // Each port hits at most one entry, so the OR-reduction routes that entry's release back.
   always_comb begin
      rel_d   = '0;
      relSd_d = '0;
      for (int p = 0; p < int'(N_PORTS); p++) begin
         for (int e = 0; e < int'(N_REGS); e++) begin
            if (hit[e][p] && entryRel[e]) begin
               rel_d[p]   = 1'b1;
               relSd_d[p] = entryRelSd[e];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
         rel_q   <= '0;
         relSd_q <= '0;
      end else begin
         rel_q   <= rel_d;
         relSd_q <= relSd_d;
      end
   end

   assign rel_o    = rel_q;
   assign rel_sd_o = relSd_q;

`ifdef FRACTAL_SYNC_CNT_RF_ERR_EN
   logic [N_PORTS-1:0] err_d, err_q;

   always_comb begin
      err_d = '0;
      for (int e = 0; e < int'(N_REGS); e++) begin
         err_d = err_d | entryErr[e];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
         err_q <= '0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_o = err_q;
`else
   logic unusedErr;
   assign unusedErr = ^entryErr;
   assign err_o     = '0;
`endif

endmodule

// File: tb/tb_fractal_sync_cnt_rf.sv
// Scoreboard bench for fractal_sync_cnt_rf (default parameters, 2 ports, 4 entries).
// Expected responses come from a behavioural barrier model and are queued per driven cycle.
module tb_fractal_sync_cnt_rf;

   localparam int SDW = fractal_sync_pkg::SD_WIDTH;

   logic                  clk;
   logic                  rstN;
   logic                  flush;
   logic [1:0]            arrive;
   logic [1:0][1:0]       idx;
   logic [1:0][3:0]       tgt;
   logic [1:0][SDW-1:0]   sd;
   logic [1:0]            presentO;
   logic [1:0]            relO;
   logic [1:0][SDW-1:0]   relSdO;
   logic [1:0]            errO;

   typedef struct packed {
      logic [1:0]          rel;
      logic [1:0][SDW-1:0] relSd;
      logic [1:0]          err;
   } exp_t;

   exp_t     expQ[$];
   int       checks;
   int       errors;
   int       mCnt[4];
   int       mTgt[4];
   logic [SDW-1:0] mSd[4];

   fractal_sync_cnt_rf dut (
      .clk_i     (clk),
      .rst_ni    (rstN),
      .flush_i   (flush),
      .arrive_i  (arrive),
      .idx_i     (idx),
      .tgt_i     (tgt),
      .sd_i      (sd),
      .present_o (presentO),
      .rel_o     (relO),
      .rel_sd_o  (relSdO),
      .err_o     (errO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("[TB] FAIL %s observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic clearModel();
      for (int e = 0; e < 4; e++) begin
         mCnt[e] = 0;
         mTgt[e] = 0;
         mSd[e]  = '0;
      end
   endtask

   // Drive one cycle, check present_o, queue the model's response and compare it after the edge.
   task automatic applyStimulus(input logic [1:0] arr, input logic [1:0] i0, input logic [1:0] i1,
                                input logic [3:0] t0, input logic [3:0] t1,
                                input logic [SDW-1:0] s0, input logic [SDW-1:0] s1,
                                input logic fl);
      exp_t ex;
      exp_t got;
      logic [1:0] expPresent;
      @(negedge clk);
      arrive = arr; idx[0] = i0; idx[1] = i1; tgt[0] = t0; tgt[1] = t1;
      sd[0] = s0; sd[1] = s1; flush = fl;
      #1;
      expPresent[0] = arr[0] && (mCnt[i0] != 0);
      expPresent[1] = arr[1] && (mCnt[i1] != 0);
      checkOutput("present", 32'(presentO), 32'(expPresent));

      ex = '0;
      if (fl) begin
         clearModel();
      end else begin
         for (int e = 0; e < 4; e++) begin
            int n;
            int first;
            int t;
            logic [SDW-1:0] m;
            n = 0; first = -1; m = '0;
            for (int p = 0; p < 2; p++) begin
               if (arr[p] && idx[p] == 2'(e)) begin
                  n++;
                  m = m | sd[p];
                  if (first < 0) first = p;
               end
            end
            if (n > 0) begin
               t = (mCnt[e] == 0) ? int'(tgt[first]) : mTgt[e];
`ifdef FRACTAL_SYNC_CNT_RF_ERR_EN
               for (int p = 0; p < 2; p++) begin
                  if (arr[p] && idx[p] == 2'(e) && int'(tgt[p]) != t) ex.err[p] = 1'b1;
               end
`endif
               if (mCnt[e] + n >= ((t == 0) ? 1 : t)) begin
                  for (int p = 0; p < 2; p++) begin
                     if (arr[p] && idx[p] == 2'(e)) begin
                        ex.rel[p]   = 1'b1;
                        ex.relSd[p] = mSd[e] | m;
                     end
                  end
                  mCnt[e] = 0; mTgt[e] = 0; mSd[e] = '0;
               end else begin
                  if (mCnt[e] == 0) mTgt[e] = t;
                  mCnt[e] = mCnt[e] + n;
                  mSd[e]  = mSd[e] | m;
               end
            end
         end
      end
      expQ.push_back(ex);

      @(posedge clk);
      #1;
      got.rel = relO; got.relSd = relSdO; got.err = errO;
      if (expQ.size() == 0) begin
         checkOutput("queueEmpty", 32'(1), 32'(0));
      end else begin
         ex = expQ.pop_front();
         checkOutput("rel", 32'(got.rel), 32'(ex.rel));
         checkOutput("relSd", 32'(got.relSd), 32'(ex.relSd));
         checkOutput("err", 32'(got.err), 32'(ex.err));
      end
   endtask

   task automatic applyReset(input logic [1:0] arr);
      @(negedge clk);
      rstN = 1'b0; arrive = arr; idx[0] = 2'd1; idx[1] = 2'd1;
      tgt[0] = 4'd1; tgt[1] = 4'd1; sd[0] = 4'h3; sd[1] = 4'h5; flush = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rstRel", 32'(relO), 32'(0));
      checkOutput("rstRelSd", 32'(relSdO), 32'(0));
      checkOutput("rstErr", 32'(errO), 32'(0));
      clearModel();
      @(negedge clk);
      rstN = 1'b1; arrive = '0;
   endtask

   initial begin
      checks = 0; errors = 0;
      rstN = 1'b0; flush = 1'b0; arrive = '0; idx = '0; tgt = '0; sd = '0;
      clearModel();
      repeat (2) @(posedge clk);
      applyReset(2'b00);

      // Sequential barrier at entry 1, target 3, completing on port 0.
      applyStimulus(2'b01, 2'd1, 2'd0, 4'd3, 4'd0, 4'h1, 4'h0, 1'b0);
      applyStimulus(2'b10, 2'd0, 2'd1, 4'd0, 4'd3, 4'h0, 4'h2, 1'b0);
      applyStimulus(2'b01, 2'd1, 2'd0, 4'd3, 4'd0, 4'h4, 4'h0, 1'b0);
      applyStimulus(2'b00, 2'd0, 2'd0, 4'd0, 4'd0, 4'h0, 4'h0, 1'b0);

      // Simultaneous arrivals at entry 2, target 2.
      applyStimulus(2'b11, 2'd2, 2'd2, 4'd2, 4'd2, 4'h1, 4'h8, 1'b0);
      applyStimulus(2'b00, 2'd0, 2'd0, 4'd0, 4'd0, 4'h0, 4'h0, 1'b0);

      // Independent entries, target 1 each.
      applyStimulus(2'b11, 2'd0, 2'd3, 4'd1, 4'd1, 4'h2, 4'h4, 1'b0);

      // Target 0 releases on the first arrival.
      applyStimulus(2'b10, 2'd0, 2'd0, 4'd0, 4'd0, 4'h0, 4'h6, 1'b0);

      // Maximum target: 15 arrivals, only the last releases.
      for (int k = 0; k < 15; k++) begin
         applyStimulus(2'b01, 2'd3, 2'd0, 4'd15, 4'd0, 4'(1 << (k % 4)), 4'h0, 1'b0);
      end

      // Partial barrier discarded by reset, then a fresh arrival must see an empty entry.
      applyStimulus(2'b11, 2'd1, 2'd1, 4'd5, 4'd5, 4'h1, 4'h2, 1'b0);
      applyReset(2'b11);
      applyStimulus(2'b01, 2'd1, 2'd0, 4'd2, 4'd0, 4'h8, 4'h0, 1'b0);

      // Flush with same-cycle arrivals that would otherwise complete the barrier.
      applyStimulus(2'b11, 2'd1, 2'd1, 4'd2, 4'd2, 4'h1, 4'h2, 1'b1);
      applyStimulus(2'b01, 2'd1, 2'd0, 4'd1, 4'd0, 4'h4, 4'h0, 1'b0);

      // Target mismatch: counted anyway, release after four arrivals.
      applyStimulus(2'b01, 2'd2, 2'd0, 4'd4, 4'd0, 4'h1, 4'h0, 1'b0);
      applyStimulus(2'b10, 2'd0, 2'd2, 4'd0, 4'd5, 4'h0, 4'h2, 1'b0);
      applyStimulus(2'b11, 2'd2, 2'd2, 4'd4, 4'd4, 4'h4, 4'h8, 1'b0);

      // Fresh entry with differing same-cycle targets.
      applyStimulus(2'b11, 2'd3, 2'd3, 4'd3, 4'd6, 4'h1, 4'h2, 1'b0);
      applyStimulus(2'b01, 2'd3, 2'd0, 4'd3, 4'd0, 4'h4, 4'h0, 1'b0);

      for (int k = 0; k < 300; k++) begin
         applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                       4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)),
                       4'($urandom), 4'($urandom), ($urandom_range(0, 24) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
